stream_demux2: RTL
==================

// Module: stream_demux2
// PURPOSE
//  Registered 1-to-2 stream demultiplexer: one producer, two consumers, valid/ready on all sides.
//  Each input word is steered by in_sel: 1 -> port A, 0 -> port B, the same polarity as the 2:1 mux select.
//  Splits a shared game-data stream (sprite/score/event words) between two downstream engines.
//  Keeps a per-port delivered-word count for debug.
// PARAMETERS
//  WIDTH  8   data word width in bits
//  CNT_W  16  width of each delivered-word counter; counter wraps modulo 2^CNT_W
// PORTS
//  clk       in   1       system clock; all state updates on rising edge
//  rst_n     in   1       synchronous reset, active low
//  in_valid  in   1       producer has a word on in_data/in_sel
//  in_ready  out  1       block accepts the word this cycle
//  in_sel    in   1       destination: 1 = port A, 0 = port B; sampled with in_data
//  in_data   in   WIDTH   input word
//  a_valid   out  1       port A holds a word
//  a_ready   in   1       consumer A takes the word this cycle
//  a_data    out  WIDTH   port A word
//  b_valid   out  1       port B holds a word
//  b_ready   in   1       consumer B takes the word this cycle
//  b_data    out  WIDTH   port B word
//  a_count   out  CNT_W   words delivered on A (a_valid & a_ready)
//  b_count   out  CNT_W   words delivered on B (b_valid & b_ready)
// BEHAVIOUR
//  - Reset: rst_n sampled low at a clk edge clears a_valid, b_valid, a_data, b_data, a_count and b_count to 0.
//    While rst_n is low, in_ready = 0. Reset mid-transfer discards both held words without delivering them.
//  - Each port is a one-entry register with two states, EMPTY (valid = 0) and FULL (valid = 1).
//  - Port X can load when it is EMPTY, or when it is FULL and X_ready = 1 (drain and refill in the same cycle).
//  - in_ready = rst_n & (in_sel ? canload_A : canload_B). Combinational from in_sel, a_ready/b_ready and state.
//  - Accept = in_valid & in_ready. On accept, the selected port loads in_data and sets valid = 1.
//    The other port is not affected.
//  - Latency: a word accepted at edge N is visible on X_data/X_valid after edge N, one cycle. No combinational in->out data path.
//  - While X_valid = 1 and X_ready = 0, X_data and X_valid are held stable (no overwrite, no drop).
//  - X_valid & X_ready with no new load for X: X goes to EMPTY and X_valid = 0. X_data keeps its old value.
//  - The ports are independent. A stalled port A does not block traffic to B: in_ready follows in_sel each cycle.
//    Words for one port are delivered in acceptance order. No order is guaranteed between A and B.
//  - No accept when in_valid = 1 and in_ready = 0. The producer holds the word; in_sel may change while stalled.
//  - Counters: X_count += 1 on each X_valid & X_ready cycle, independent of loads.
//    All-ones + 1 wraps to 0. Counters never saturate.
//  - Simultaneous events: A drain, B drain and an accept to either port in one cycle are all legal.
//    All three take effect at the same edge.
//  - Throughput: 1 word/cycle per port when that consumer keeps ready = 1.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0; all valids, data and counts = 0.
//    After release, in_ready=1.
//  2 Steering: send 0x11 sel=1 then 0x22 sel=0, ready=1 on both ports
//    -> a_data=0x11 one cycle after its accept, b_data=0x22 one cycle after its accept; a_count=1, b_count=1.
//  3 Stall and hold: a_ready=0, send 0x5A sel=1, then a second word sel=1
//    -> in_ready=0, a_data stays 0x5A. Raise a_ready -> 0x5A delivered, then the second word, in order.
//  4 Independence: A stalled and full, send 0x33 sel=0
//    -> accepted at once and 0x33 appears on B while A still holds its word.
//  5 Back-to-back: 8 words sel=1, a_ready=1 throughout -> one accept per cycle; a_count=8; data order preserved.
//  6 Wrap and reset: CNT_W=4, deliver 17 words to B -> b_count=1.
//    Assert rst_n=0 while b_valid=1 -> b_valid=0, b_count=0 at the next edge.

Source files
------------

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer with valid/ready handshakes on all sides.
// in_sel = 1 steers a word to port A, 0 to port B; each port keeps a delivered-word count.
module stream_demux2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } port_state_t;

    port_state_t      r_a_state;
    port_state_t      r_b_state;
    port_state_t      w_a_state_nxt;
    port_state_t      w_b_state_nxt;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    logic w_a_full;
    logic w_b_full;
    logic w_a_canload;
    logic w_b_canload;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_drain_a;
    logic w_drain_b;

    always_comb begin
        w_a_full    = (r_a_state == S_FULL);
        w_b_full    = (r_b_state == S_FULL);
        // A full slot may refill in the same cycle its consumer drains it.
        w_a_canload = !w_a_full || a_ready;
        w_b_canload = !w_b_full || b_ready;
        in_ready    = rst_n && (in_sel ? w_a_canload : w_b_canload);
        w_accept    = in_valid && in_ready;
        w_load_a    = w_accept && in_sel;
        w_load_b    = w_accept && !in_sel;
        w_drain_a   = w_a_full && a_ready;
        w_drain_b   = w_b_full && b_ready;
    end

    always_comb begin
        w_a_state_nxt = r_a_state;
        w_b_state_nxt = r_b_state;
        if (w_load_a) begin
            w_a_state_nxt = S_FULL;
        end else if (w_drain_a) begin
            w_a_state_nxt = S_EMPTY;
        end
        if (w_load_b) begin
            w_b_state_nxt = S_FULL;
        end else if (w_drain_b) begin
            w_b_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_state <= S_EMPTY;
            r_b_state <= S_EMPTY;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_data <= '0;
            r_b_data <= '0;
        end else begin
            if (w_load_a) begin
                r_a_data <= in_data;
            end
            if (w_load_b) begin
                r_b_data <= in_data;
            end
        end
    end

    // Counters wrap naturally; they track handshakes, not loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_drain_a) begin
                r_a_count <= r_a_count + 1'b1;
            end
            if (w_drain_b) begin
                r_b_count <= r_b_count + 1'b1;
            end
        end
    end

    assign a_valid = w_a_full;
    assign b_valid = w_b_full;
    assign a_data  = r_a_data;
    assign b_data  = r_b_data;
    assign a_count = r_a_count;
    assign b_count = r_b_count;

endmodule
